// File: rtl/param_assoc_cache.sv
// N-way set-associative, write-back, write-allocate line cache between a CPU-side
// wishbone master and a memory-side wishbone slave, with tree-PLRU and saturating counters.
module param_assoc_cache #(
  parameter int WAYS   = 4,
  parameter int SETS   = 8,
  parameter int ADDR_W = 12,
  parameter int LINE_W = 128,
  parameter int SEL_W  = LINE_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cyc,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  input  logic [SEL_W-1:0]  cpu_sel,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [LINE_W-1:0] cpu_dat_m,
  output logic [LINE_W-1:0] cpu_dat_s,
  output logic              cpu_ack,
  output logic              cpu_rty,
  output logic              mem_cyc,
  output logic              mem_stb,
  output logic              mem_we,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [LINE_W-1:0] mem_dat_m,
  input  logic [LINE_W-1:0] mem_dat_s,
  input  logic              mem_ack,
  input  logic              mem_rty,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  // Handshake: a CPU request is cyc&stb held stable until a one-cycle cpu_ack; a memory
  // transfer holds cyc/stb/we/adr/dat until mem_ack, and mem_rty simply re-issues the strobe.
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
  state_t state;

  logic [LINE_W-1:0] data_mem [SETS][WAYS];
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  logic [WAYS-2:0]   plru     [SETS];

  logic [ADDR_W-1:0] req_adr;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              first_lookup;
  logic [WAY_W-1:0]  victim;

  logic [WAYS-1:0]   hit_vec;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  inv_way;
  logic              any_inv;
  logic              hit;
  logic [WAY_W-1:0]  new_victim;
  logic [LINE_W-1:0] merged;
  logic              req;
  logic              hit_inc;
  logic              miss_inc;
  logic              wb_inc;

  // Each tree bit points toward the half that holds the next victim (0 = lower half).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + int'(bits[node-1]);
    return WAY_W'(node - WAYS);
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] b;
    logic            dir;
    int              node;
    b    = bits;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      dir         = way[WAY_W-1-l];
      b[node-1]   = ~dir;
      node        = 2 * node + int'(dir);
    end
    return b;
  endfunction

  assign idx     = req_adr[IDX_W-1:0];
  assign req_tag = req_adr[ADDR_W-1:IDX_W];
  assign req     = cpu_cyc & cpu_stb;
  assign cpu_rty = cpu_cyc & cpu_stb & ~cpu_ack;
  assign mem_sel = '1;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid[idx][w] && (tag_mem[idx][w] == req_tag);
      if (valid[idx][w] && (tag_mem[idx][w] == req_tag)) hit_way = WAY_W'(w);
      if (!valid[idx][w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  // A hit requires exactly one matching way.
  assign hit        = (hit_vec != '0) && ((hit_vec & (hit_vec - WAYS'(1))) == '0);
  assign new_victim = any_inv ? inv_way : plru_victim(plru[idx]);

  always_comb begin
    merged = data_mem[idx][hit_way];
    for (int b = 0; b < SEL_W; b++) begin
      if (cpu_sel[b]) merged[8*b +: 8] = cpu_dat_m[8*b +: 8];
    end
  end

  assign hit_inc  = (state == CHECK) && req && hit && first_lookup;
  assign miss_inc = (state == FILL) && mem_ack;
  assign wb_inc   = (state == WRITEBACK) && mem_ack;

  // Line and tag storage carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (state == CHECK && req && hit && cpu_we) data_mem[idx][hit_way] <= merged;
    if (state == FILL && mem_ack) begin
      data_mem[idx][victim] <= mem_dat_s;
      tag_mem[idx][victim]  <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
      req_adr      <= '0;
      first_lookup <= 1'b0;
      victim       <= '0;
      cpu_ack      <= 1'b0;
      cpu_dat_s    <= '0;
      mem_cyc      <= 1'b0;
      mem_stb      <= 1'b0;
      mem_we       <= 1'b0;
      mem_adr      <= '0;
      mem_dat_m    <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      wb_count     <= '0;
    end else begin
      cpu_ack <= 1'b0;

      if (cnt_clr) begin
        hit_count  <= '0;
        miss_count <= '0;
        wb_count   <= '0;
      end else begin
        if (hit_inc && hit_count != '1)   hit_count  <= hit_count + CNT_W'(1);
        if (miss_inc && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        if (wb_inc && wb_count != '1)     wb_count   <= wb_count + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          // The ack cycle still shows the old request on the bus; do not re-accept it.
          if (req && !cpu_ack) begin
            req_adr      <= cpu_adr;
            first_lookup <= 1'b1;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (!req) begin
            state <= IDLE;
          end else if (hit) begin
            cpu_ack   <= 1'b1;
            if (cpu_we) dirty[idx][hit_way] <= 1'b1;
            else        cpu_dat_s <= data_mem[idx][hit_way];
            plru[idx] <= plru_touch(plru[idx], hit_way);
            state     <= IDLE;
          end else begin
            victim       <= new_victim;
            first_lookup <= 1'b0;
            mem_cyc      <= 1'b1;
            mem_stb      <= 1'b1;
            if (valid[idx][new_victim] && dirty[idx][new_victim]) begin
              mem_we    <= 1'b1;
              mem_adr   <= {tag_mem[idx][new_victim], idx};
              mem_dat_m <= data_mem[idx][new_victim];
              state     <= WRITEBACK;
            end else begin
              mem_we  <= 1'b0;
              mem_adr <= req_adr;
              state   <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            mem_we  <= 1'b0;
            mem_adr <= req_adr;
            state   <= FILL;
          end else if (mem_rty) begin
            mem_stb <= 1'b1;
          end
        end
        FILL: begin
          if (mem_ack) begin
            mem_cyc              <= 1'b0;
            mem_stb              <= 1'b0;
            valid[idx][victim]   <= 1'b1;
            dirty[idx][victim]   <= 1'b0;
            state                <= CHECK;
          end else if (mem_rty) begin
            mem_stb <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_assoc_cache.sv
// Bench for param_assoc_cache: two configurations behind one shared bus, a memory responder
// with delays/retries, and a line-residency reference model of the cache.
module tb_param_assoc_cache;
  localparam int ADDR_W = 12;
  localparam int LINE_W = 128;
  localparam int SEL_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              sel_dut;
  logic              cpu_cyc, cpu_stb, cpu_we, cnt_clr;
  logic [SEL_W-1:0]  cpu_sel;
  logic [ADDR_W-1:0] cpu_adr;
  logic [LINE_W-1:0] cpu_dat_m, mem_dat_s;
  logic              mem_ack, mem_rty;

  logic [LINE_W-1:0] a_dat_s, b_dat_s, a_mdat, b_mdat, cpu_dat_s, mem_dat_m;
  logic              a_ack, b_ack, a_rty, b_rty, cpu_ack, cpu_rty;
  logic              a_mcyc, b_mcyc, a_mstb, b_mstb, a_mwe, b_mwe, mem_cyc, mem_stb, mem_we;
  logic [SEL_W-1:0]  a_msel, b_msel, mem_sel;
  logic [ADDR_W-1:0] a_madr, b_madr, mem_adr;
  logic [7:0]        a_hit, a_miss, a_wb;
  logic [15:0]       b_hit, b_miss, b_wb, hit_count, miss_count, wb_count;

  param_assoc_cache #(.WAYS(4), .SETS(8), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .cpu_cyc(cpu_cyc & ~sel_dut), .cpu_stb(cpu_stb & ~sel_dut),
    .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_adr(cpu_adr), .cpu_dat_m(cpu_dat_m),
    .cpu_dat_s(a_dat_s), .cpu_ack(a_ack), .cpu_rty(a_rty), .mem_cyc(a_mcyc), .mem_stb(a_mstb),
    .mem_we(a_mwe), .mem_sel(a_msel), .mem_adr(a_madr), .mem_dat_m(a_mdat), .mem_dat_s(mem_dat_s),
    .mem_ack(mem_ack & ~sel_dut), .mem_rty(mem_rty & ~sel_dut), .cnt_clr(cnt_clr),
    .hit_count(a_hit), .miss_count(a_miss), .wb_count(a_wb));

  param_assoc_cache #(.WAYS(2), .SETS(16), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .cpu_cyc(cpu_cyc & sel_dut), .cpu_stb(cpu_stb & sel_dut),
    .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_adr(cpu_adr), .cpu_dat_m(cpu_dat_m),
    .cpu_dat_s(b_dat_s), .cpu_ack(b_ack), .cpu_rty(b_rty), .mem_cyc(b_mcyc), .mem_stb(b_mstb),
    .mem_we(b_mwe), .mem_sel(b_msel), .mem_adr(b_madr), .mem_dat_m(b_mdat), .mem_dat_s(mem_dat_s),
    .mem_ack(mem_ack & sel_dut), .mem_rty(mem_rty & sel_dut), .cnt_clr(cnt_clr),
    .hit_count(b_hit), .miss_count(b_miss), .wb_count(b_wb));

  assign cpu_dat_s  = sel_dut ? b_dat_s : a_dat_s;
  assign cpu_ack    = sel_dut ? b_ack   : a_ack;
  assign cpu_rty    = sel_dut ? b_rty   : a_rty;
  assign mem_cyc    = sel_dut ? b_mcyc  : a_mcyc;
  assign mem_stb    = sel_dut ? b_mstb  : a_mstb;
  assign mem_we     = sel_dut ? b_mwe   : a_mwe;
  assign mem_sel    = sel_dut ? b_msel  : a_msel;
  assign mem_adr    = sel_dut ? b_madr  : a_madr;
  assign mem_dat_m  = sel_dut ? b_mdat  : a_mdat;
  assign hit_count  = sel_dut ? b_hit   : {8'h00, a_hit};
  assign miss_count = sel_dut ? b_miss  : {8'h00, a_miss};
  assign wb_count   = sel_dut ? b_wb    : {8'h00, a_wb};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [11:0] a);
    logic [31:0] h;
    h = 32'h1234_5678 ^ ({20'h0, a} * 32'h9E37_79B1);
    return {h, ~h, h + 32'h1, h ^ 32'hA5A5_A5A5};
  endfunction

  // ---------------- memory responder ----------------
  logic [127:0] mem_store [logic [11:0]];
  logic         log_we  [$];
  logic [11:0]  log_adr [$];
  logic [127:0] log_dat [$];
  int cfg_delay = -1;
  int cfg_rty   = -1;

  initial begin
    bit active;
    int dly, rl;
    active = 0; dly = 0; rl = 0;
    mem_ack = 0; mem_rty = 0; mem_dat_s = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 0; mem_rty = 0;
      if (rst) begin
        active = 0;
      end else if (mem_cyc && mem_stb) begin
        if (!active) begin
          active = 1;
          dly = (cfg_delay < 0) ? $urandom_range(0, 4) : cfg_delay;
          rl  = (cfg_rty < 0) ? $urandom_range(0, dly) : cfg_rty;
        end
        if (dly > 0) begin
          dly--;
          if (rl > 0) begin mem_rty = 1; rl--; end
        end else begin
          active = 0;
          mem_ack = 1;
          log_we.push_back(mem_we);
          log_adr.push_back(mem_adr);
          if (mem_we) begin
            mem_store[mem_adr] = mem_dat_m;
            log_dat.push_back(mem_dat_m);
          end else begin
            mem_dat_s = mem_store.exists(mem_adr) ? mem_store[mem_adr] : init_line(mem_adr);
            log_dat.push_back(mem_dat_s);
          end
        end
      end else if (active) begin
        check("mem_stb_held", 1'b0, 1'b1);
        active = 0;
      end
    end
  end

  // ---------------- reference model: resident lines per set ----------------
  bit           m_valid [16][8];
  bit           m_dirty [16][8];
  logic [11:0]  m_adr   [16][8];
  logic [127:0] m_data  [16][8];
  bit           m_plru  [16][16];
  logic [127:0] ref_mem [logic [11:0]];
  int m_ways = 4, m_sets = 8;
  int unsigned cnt_max = 255;
  int unsigned exp_hit = 0, exp_miss = 0, exp_wb = 0;

  function automatic int unsigned sat(input int unsigned v);
    return (v > cnt_max) ? cnt_max : v;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 8; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
      for (int n = 0; n < 16; n++) m_plru[s][n] = 0;
    end
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
  endfunction

  // Binary search over the way range; a set node bit means "victim lies in the upper half".
  function automatic int model_victim(input int s);
    int lo, hi, node, mid;
    lo = 0; hi = m_ways; node = 1;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_plru[s][node]) begin lo = mid; node = 2 * node + 1; end
      else                 begin hi = mid; node = 2 * node; end
    end
    return lo;
  endfunction

  function automatic void model_touch(input int s, input int w);
    int lo, hi, node, mid;
    lo = 0; hi = m_ways; node = 1;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_plru[s][node] = 1; hi = mid; node = 2 * node; end
      else         begin m_plru[s][node] = 0; lo = mid; node = 2 * node + 1; end
    end
  endfunction

  function automatic void predict(input logic [11:0] a, output bit hit, output int way,
                                  output bit wb, output logic [11:0] wb_adr,
                                  output logic [127:0] wb_dat);
    int s;
    s = int'(a) % m_sets;
    hit = 0; way = -1; wb = 0; wb_adr = '0; wb_dat = '0;
    for (int w = 0; w < m_ways; w++)
      if (m_valid[s][w] && m_adr[s][w] == a) begin hit = 1; way = w; end
    if (!hit) begin
      for (int w = m_ways - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) way = model_victim(s);
      wb     = m_valid[s][way] && m_dirty[s][way];
      wb_adr = m_adr[s][way];
      wb_dat = m_data[s][way];
    end
  endfunction

  function automatic void commit(input logic [11:0] a, input bit we, input logic [15:0] sel,
                                 input logic [127:0] dat, input bit abandon, input bit clr);
    bit hit, wb; int way, s; logic [11:0] wba; logic [127:0] wbd;
    predict(a, hit, way, wb, wba, wbd);
    s = int'(a) % m_sets;
    if (!hit) begin
      if (wb) begin ref_mem[wba] = wbd; exp_wb = sat(exp_wb + 1); end
      m_data[s][way]  = ref_mem.exists(a) ? ref_mem[a] : init_line(a);
      m_adr[s][way]   = a;
      m_valid[s][way] = 1;
      m_dirty[s][way] = 0;
      exp_miss = sat(exp_miss + 1);
    end
    if (abandon) return;
    if (hit) exp_hit = sat(exp_hit + 1);
    model_touch(s, way);
    if (we) begin
      for (int b = 0; b < 16; b++) if (sel[b]) m_data[s][way][8*b +: 8] = dat[8*b +: 8];
      m_dirty[s][way] = 1;
    end
    if (clr) begin exp_hit = 0; exp_miss = 0; exp_wb = 0; end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_counts(input string tag);
    check({tag, "_hit_count"},  hit_count,  exp_hit);
    check({tag, "_miss_count"}, miss_count, exp_miss);
    check({tag, "_wb_count"},   wb_count,   exp_wb);
  endtask

  task automatic clear_log();
    log_we.delete(); log_adr.delete(); log_dat.delete();
  endtask

  task automatic do_reset();
    rst = 1; cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_dat_s", cpu_dat_s, 0);
    check("rst_mem_cyc", mem_cyc, 0);
    check("rst_mem_stb", mem_stb, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_sel", mem_sel, 16'hFFFF);
    check_counts("rst");
  endtask

  task automatic do_req(input bit we, input logic [11:0] a, input logic [15:0] sel,
                        input logic [127:0] dat, input bit clr, output bit obs_hit);
    bit hit, wb, got; int way, cyc, s; logic [11:0] wba; logic [127:0] wbd;
    predict(a, hit, way, wb, wba, wbd);
    clear_log();
    cpu_cyc = 1; cpu_stb = 1; cpu_we = we; cpu_adr = a; cpu_sel = sel; cpu_dat_m = dat;
    cyc = 0; got = 0;
    while (!got && cyc < 300) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        check("rty_pending", cpu_rty, 1);
        if (clr) cnt_clr = 1;
      end
      if (cpu_ack) got = 1;
    end
    check("ack_seen", got, 1);
    cnt_clr = 0;
    commit(a, we, sel, dat, 0, clr);
    s = int'(a) % m_sets;
    if (!we) check("read_data", cpu_dat_s, m_data[s][way]);
    check("rty_at_ack", cpu_rty, 0);
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0;
    @(posedge clk); #1;
    obs_hit = (log_adr.size() == 0);
    check("hit_status", obs_hit, hit);
    if (hit) begin
      check("hit_latency", cyc, 2);
    end else begin
      check("txn_count", log_adr.size(), wb ? 2 : 1);
      if (wb && log_adr.size() == 2) begin
        check("wb_we", log_we[0], 1);
        check("wb_adr", log_adr[0], wba);
        check("wb_dat", log_dat[0], wbd);
      end
      if (log_adr.size() >= 1) begin
        check("fill_we", log_we[log_adr.size()-1], 0);
        check("fill_adr", log_adr[log_adr.size()-1], a);
      end
    end
    check_counts("req");
  endtask

  task automatic do_abandon(input logic [11:0] a);
    bit hit, wb, acked; int way, n; logic [11:0] wba; logic [127:0] wbd;
    predict(a, hit, way, wb, wba, wbd);
    check("abandon_pre_miss", hit, 0);
    clear_log();
    cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_adr = a;
    n = 0;
    while (!mem_stb && n < 50) begin @(negedge clk); n++; end
    check("abandon_mem_start", mem_stb, 1);
    cpu_cyc = 0; cpu_stb = 0;
    acked = 0; n = 0;
    while (mem_cyc && n < 100) begin @(negedge clk); n++; if (cpu_ack) acked = 1; end
    repeat (4) begin @(negedge clk); if (cpu_ack) acked = 1; end
    check("abandon_no_ack", acked, 0);
    check("abandon_txns", log_adr.size(), wb ? 2 : 1);
    commit(a, 0, '0, '0, 1, 0);
    @(posedge clk); #1;
    check_counts("abandon");
  endtask

  task automatic random_phase(input int n, input int max_tag, input int max_idx);
    bit h; logic [11:0] a; int sh;
    sh = (m_sets == 16) ? 4 : 3;
    for (int i = 0; i < n; i++) begin
      a = 12'(($urandom_range(0, max_tag) << sh) | $urandom_range(0, max_idx));
      do_req(($urandom_range(0, 2) == 0), a, 16'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, 0, h);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit h, found, hit, wb; int way, n; logic [11:0] a, wba; logic [127:0] wbd;
    sel_dut = 0; cpu_sel = '0; cpu_adr = '0; cpu_dat_m = '0;
    do_reset();
    check_reset_outputs();

    cfg_delay = 3; cfg_rty = 0;
    do_req(0, 12'h010, '0, '0, 0, h);
    check("first_read_miss", h, 0);
    do_req(0, 12'h010, '0, '0, 0, h);
    check("reread_hit", h, 1);
    check("reread_hit_count", hit_count, 1);

    cfg_delay = -1; cfg_rty = -1;
    do_req(1, 12'h010, 16'h0001, 128'h5A, 0, h);
    check("write_hit", h, 1);
    do_req(0, 12'h018, '0, '0, 0, h);
    do_req(0, 12'h020, '0, '0, 0, h);
    do_req(0, 12'h028, '0, '0, 0, h);
    do_req(0, 12'h030, '0, '0, 0, h);
    check("evict_txns", log_adr.size(), 2);
    if (log_adr.size() == 2) begin
      check("evict_wb_adr", log_adr[0], 12'h010);
      check("evict_wb_byte0", log_dat[0][7:0], 8'h5A);
    end
    check("evict_wb_count", wb_count, 1);

    cfg_delay = 3; cfg_rty = 2;
    n = miss_count;
    do_req(0, 12'h038, '0, '0, 0, h);
    check("rty_one_install", log_adr.size() >= 1, 1);
    check("rty_miss_inc", miss_count, n + 1);
    cfg_delay = -1; cfg_rty = -1;

    do_abandon(12'hFF0);
    do_req(0, 12'hFF0, '0, '0, 0, h);
    check("abandon_then_hit", h, 1);

    do_req(1, 12'h100, 16'hFFFF, {4{32'hDEAD_BEEF}}, 0, h);
    found = 0;
    for (int k = 1; k < 30 && !found; k++) begin
      a = 12'h100 + 12'(k * 8);
      predict(a, hit, way, wb, wba, wbd);
      if (wb) found = 1;
      else do_req(0, a, '0, '0, 0, h);
    end
    check("wb_candidate_found", found, 1);
    if (found) begin
      cfg_delay = 8;
      cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_adr = a;
      n = 0;
      while (!(mem_stb && mem_we) && n < 50) begin @(negedge clk); n++; end
      check("wb_started", mem_stb && mem_we, 1);
      rst = 1;
      #1;
      check("rst_drops_mem_cyc", mem_cyc, 0);
      check("rst_drops_mem_stb", mem_stb, 0);
      cpu_cyc = 0; cpu_stb = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      model_reset();
      cfg_delay = -1;
      @(posedge clk); #1;
      check_counts("post_rst");
      do_req(0, wba, '0, '0, 0, h);
      check("post_rst_miss", h, 0);
    end

    do_req(0, 12'h010, '0, '0, 0, h);
    for (int i = 0; i < 260; i++) do_req(0, 12'h010, '0, '0, 0, h);
    check("hit_saturated", hit_count, 255);
    do_req(0, 12'h010, '0, '0, 1, h);
    check("clr_hit_count", hit_count, 0);
    check("clr_miss_count", miss_count, 0);
    do_req(0, 12'h010, '0, '0, 0, h);
    check("after_clr_hit", hit_count, 1);

    random_phase(150, 7, 1);

    sel_dut = 1;
    m_ways = 2; m_sets = 16; cnt_max = 65535;
    ref_mem.delete(); mem_store.delete();
    do_reset();
    check_reset_outputs();
    do_req(0, 12'h000, '0, '0, 0, h); check("b_000_miss", h, 0);
    do_req(0, 12'h010, '0, '0, 0, h); check("b_010_miss", h, 0);
    do_req(0, 12'h000, '0, '0, 0, h); check("b_000_hit", h, 1);
    do_req(0, 12'h020, '0, '0, 0, h); check("b_020_miss", h, 0);
    do_req(0, 12'h000, '0, '0, 0, h); check("b_000_still_hit", h, 1);
    do_req(0, 12'h010, '0, '0, 0, h); check("b_010_evicted", h, 0);
    random_phase(150, 3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
